csr_write_sequencer: RTL and testbench
======================================

Name: csr_write_sequencer

Overview:
- Sits between the write-back stage and the single-write-port CSR file.
- Accepts one retiring instruction per valid/ready handshake.
- Turns each instruction into the required CSR writes:
  - plain CSR write: one write;
  - trap entry: mepc, mcause, mstatus writes;
  - mret: one mstatus write.
- Issues those writes one per cycle on the shared port, then signals completion downstream with its own valid/ready handshake.

Parameters:
- MSTATUS_ADDR, 12'h300, mstatus CSR address
- MEPC_ADDR, 12'h341, mepc CSR address
- MCAUSE_ADDR, 12'h342, mcause CSR address

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  write-back stage has an instruction to retire
- in_ready  out  1  sequencer can accept an instruction
- csr_we_i  in  1  instruction writes a CSR
- csr_addr_i  in  12  CSR address for the plain write
- csr_wdata_i  in  32  data for the plain write
- irq_i  in  1  instruction traps (exception or interrupt)
- irq_no_i  in  8  trap code; bit7 = interrupt flag, bits6:0 = code
- epc_i  in  32  PC of the trapping instruction
- mret_i  in  1  instruction is mret
- mstatus_rdata  in  32  current mstatus value from the CSR file
- csr_wen  out  1  CSR file write enable
- csr_waddr  out  12  CSR file write address
- csr_wdata  out  32  CSR file write data
- out_valid  out  1  instruction fully committed
- out_ready  in  1  downstream accepts the commit
- busy  out  1  state is not IDLE

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state = IDLE; in_ready = 1; out_valid = 0; csr_wen = 0; busy = 0.
  - Captured operands are cleared to 0.
  - Reset asserted in any state aborts the sequence at that edge. Writes not yet issued are dropped.
- States: IDLE, W_NORM, W_MEPC, W_MCAUSE, W_MSTATUS, DONE.
- in_ready = (state == IDLE).
- Accept:
  - Occurs when in_valid && in_ready at a rising edge.
  - All inputs except mstatus_rdata are captured at that edge.
  - Inputs are ignored in every other state.
- Next state from IDLE on accept, in priority order:
  - irq_i → W_MEPC.
  - else mret_i → W_MSTATUS.
  - else csr_we_i → W_NORM.
  - else → DONE.
  - irq_i suppresses both csr_we_i and mret_i.
- Write states: each lasts exactly one cycle with csr_wen = 1. csr_wen = 0 in IDLE and DONE.
  - W_NORM: waddr = captured addr, wdata = captured data. Next: DONE.
  - W_MEPC: waddr = MEPC_ADDR, wdata = {epc[31:2], 2'b00}. Next: W_MCAUSE.
  - W_MCAUSE: waddr = MCAUSE_ADDR, wdata = {irq_no[7], 24'b0, irq_no[6:0]}. Next: W_MSTATUS.
  - W_MSTATUS: waddr = MSTATUS_ADDR. Next: DONE.
    - wdata is built from mstatus_rdata sampled combinationally in this cycle.
    - Trap: bit3 (MIE) = 0; bit7 (MPIE) = old bit3; bits12:11 (MPP) = 2'b11; all other bits unchanged.
    - mret: bit3 = old bit7; bit7 = 1; bits12:11 = 2'b11; others unchanged.
- DONE:
  - out_valid = 1.
  - Held until out_ready is seen at a rising edge, then → IDLE.
  - Captured fields remain stable while waiting.
- Latency (accept at edge N):
  - plain write: csr_wen high in cycle N+1; out_valid from N+2.
  - trap: writes in N+1, N+2, N+3; out_valid from N+4.
  - mret: write in N+1; out_valid from N+2.
  - no CSR effect: out_valid from N+1.
- Back-to-back:
  - The earliest next accept is the edge after DONE completes; in_ready rises in the IDLE cycle.
  - At most one instruction is in flight. There is no skid buffer.
- csr_waddr and csr_wdata are don't-care when csr_wen = 0. They are driven to 0 for determinism.

Test Plan:
- Plain write: accept csr_we_i=1, addr 12'h305, data 32'h8000_0000, out_ready=1.
  → one cycle csr_wen=1, waddr 12'h305, wdata 32'h8000_0000; out_valid next cycle for exactly one cycle; in_ready returns 1.
- Trap with mstatus_rdata=32'h0000_0008: accept irq_i=1, irq_no_i=8'h0B, epc_i=32'h8000_0102.
  → writes in order (341, 32'h8000_0100), (342, 32'h0000_000B), (300, 32'h0000_1880); out_valid at N+4.
- Trap overrides CSR write: irq_i=1, irq_no_i=8'h87, csr_we_i=1 addr 12'h305.
  → no write to 12'h305; mcause = 32'h8000_0007.
- mret with mstatus_rdata=32'h0000_1880.
  → single write (300, 32'h0000_1888).
- Backpressure: out_ready=0 for 5 cycles after DONE.
  → out_valid held, in_ready=0, csr_wen=0; a new in_valid is not accepted until one cycle after out_ready=1.
- Reset mid-trap: assert reset in W_MCAUSE.
  → next cycle IDLE, csr_wen=0, out_valid=0, no mstatus write issued.

Source files
------------

// File: rtl/csr_write_sequencer.sv
// Serialises a retiring instruction's CSR side effects onto the single CSR write port,
// then reports the commit downstream with a valid/ready handshake.
module csr_write_sequencer #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        csr_we_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    input  logic        irq_i,
    input  logic [7:0]  irq_no_i,
    input  logic [31:0] epc_i,
    input  logic        mret_i,
    input  logic [31:0] mstatus_rdata,
    output logic        csr_wen,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_NORM    = 3'd1;
    localparam logic [2:0] W_MEPC    = 3'd2;
    localparam logic [2:0] W_MCAUSE  = 3'd3;
    localparam logic [2:0] W_MSTATUS = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic        irq_q;
    logic [7:0]  irq_no_q;
    logic [31:0] epc_q;
    logic        accept;
    logic [31:0] mstatus_trap;
    logic [31:0] mstatus_mret;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Trap wins over both mret and a plain CSR write.
                    if (irq_i) begin
                        state_d = W_MEPC;
                    end else if (mret_i) begin
                        state_d = W_MSTATUS;
                    end else if (csr_we_i) begin
                        state_d = W_NORM;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            W_NORM:    state_d = DONE;
            W_MEPC:    state_d = W_MCAUSE;
            W_MCAUSE:  state_d = W_MSTATUS;
            W_MSTATUS: state_d = DONE;
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 12'h000;
            wdata_q  <= 32'h0000_0000;
            irq_q    <= 1'b0;
            irq_no_q <= 8'h00;
            epc_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= csr_addr_i;
                wdata_q  <= csr_wdata_i;
                irq_q    <= irq_i;
                irq_no_q <= irq_no_i;
                epc_q    <= epc_i;
            end
        end
    end

    // mstatus update uses the live read data so any earlier write in this sequence is seen.
    always_comb begin
        mstatus_trap        = mstatus_rdata;
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[7]     = mstatus_rdata[3];
        mstatus_trap[12:11] = 2'b11;

        mstatus_mret        = mstatus_rdata;
        mstatus_mret[3]     = mstatus_rdata[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
    end

    always_comb begin
        csr_wen   = 1'b0;
        csr_waddr = 12'h000;
        csr_wdata = 32'h0000_0000;
        case (state_q)
            W_NORM: begin
                csr_wen   = 1'b1;
                csr_waddr = addr_q;
                csr_wdata = wdata_q;
            end
            W_MEPC: begin
                csr_wen   = 1'b1;
                csr_waddr = MEPC_ADDR;
                csr_wdata = epc_q & 32'hFFFF_FFFC;
            end
            W_MCAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = MCAUSE_ADDR;
                csr_wdata = {irq_no_q[7], 24'h00_0000, irq_no_q[6:0]};
            end
            W_MSTATUS: begin
                csr_wen   = 1'b1;
                csr_waddr = MSTATUS_ADDR;
                csr_wdata = irq_q ? mstatus_trap : mstatus_mret;
            end
            default: begin
                csr_wen   = 1'b0;
                csr_waddr = 12'h000;
                csr_wdata = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_write_sequencer.sv
// Self-checking bench: directed test-plan scenarios plus randomized traffic, all compared
// every cycle against a transaction-level model (queue of pending CSR writes).
module tb_csr_write_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        irq_i;
    logic [7:0]  irq_no_i;
    logic [31:0] epc_i;
    logic        mret_i;
    logic [31:0] mstatus_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csr_write_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .csr_we_i     (csr_we_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .irq_i        (irq_i),
        .irq_no_i     (irq_no_i),
        .epc_i        (epc_i),
        .mret_i       (mret_i),
        .mstatus_rdata(mstatus_rdata),
        .csr_wen      (csr_wen),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    // kind: 0 = fixed data, 1 = trap mstatus update, 2 = mret mstatus update
    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          kind;
    } wr_t;

    wr_t wr_q[$];
    bit  done_pend = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] trap_mstatus(input logic [31:0] old);
        return (old & ~32'h0000_1888) | 32'h0000_1800 | (((old >> 3) & 32'd1) << 7);
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] old);
        return (old & ~32'h0000_1888) | 32'h0000_1880 | (((old >> 7) & 32'd1) << 3);
    endfunction

    // Model advances on each rising edge, compares on the following falling edge.
    initial begin
        wr_t w;
        logic        e_wen;
        logic [11:0] e_addr;
        logic [31:0] e_data;
        logic        e_idle;
        forever begin
            @(posedge clk);
            if (reset) begin
                wr_q.delete();
                done_pend = 0;
            end else if (wr_q.size() > 0) begin
                void'(wr_q.pop_front());
            end else if (done_pend) begin
                if (out_ready) done_pend = 0;
            end else if (in_valid) begin
                if (irq_i) begin
                    wr_q.push_back('{12'h341, epc_i & 32'hFFFF_FFFC, 0});
                    wr_q.push_back('{12'h342, {irq_no_i[7], 24'h0, irq_no_i[6:0]}, 0});
                    wr_q.push_back('{12'h300, 32'h0, 1});
                end else if (mret_i) begin
                    wr_q.push_back('{12'h300, 32'h0, 2});
                end else if (csr_we_i) begin
                    wr_q.push_back('{csr_addr_i, csr_wdata_i, 0});
                end
                done_pend = 1;
            end

            @(negedge clk);
            e_wen  = 1'b0;
            e_addr = 12'h000;
            e_data = 32'h0;
            if (wr_q.size() > 0) begin
                w      = wr_q[0];
                e_wen  = 1'b1;
                e_addr = w.addr;
                e_data = (w.kind == 1) ? trap_mstatus(mstatus_rdata) :
                         (w.kind == 2) ? mret_mstatus(mstatus_rdata) : w.data;
            end
            e_idle = (wr_q.size() == 0) && !done_pend;
            cmp("in_ready",  32'(in_ready),  32'(e_idle));
            cmp("busy",      32'(busy),      32'(!e_idle));
            cmp("out_valid", 32'(out_valid), 32'((wr_q.size() == 0) && done_pend));
            cmp("csr_wen",   32'(csr_wen),   32'(e_wen));
            cmp("csr_waddr", 32'(csr_waddr), 32'(e_addr));
            cmp("csr_wdata", csr_wdata,      e_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic we, input logic [11:0] addr, input logic [31:0] data,
                             input logic irq, input logic [7:0] irq_no, input logic [31:0] epc,
                             input logic mret);
        in_valid    = 1'b1;
        csr_we_i    = we;
        csr_addr_i  = addr;
        csr_wdata_i = data;
        irq_i       = irq;
        irq_no_i    = irq_no;
        epc_i       = epc;
        mret_i      = mret;
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        csr_we_i      = 1'b0;
        csr_addr_i    = 12'h0;
        csr_wdata_i   = 32'h0;
        irq_i         = 1'b0;
        irq_no_i      = 8'h0;
        epc_i         = 32'h0;
        mret_i        = 1'b0;
        mstatus_rdata = 32'h0;
        out_ready     = 1'b1;
        step();
        cmp("rst_in_ready", 32'(in_ready), 32'd1);
        cmp("rst_out_valid", 32'(out_valid), 32'd0);
        cmp("rst_csr_wen", 32'(csr_wen), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Plain write
        set_instr(1'b1, 12'h305, 32'h8000_0000, 1'b0, 8'h00, 32'h0, 1'b0);
        step();
        in_valid = 1'b0;
        cmp("plain_wen", 32'(csr_wen), 32'd1);
        cmp("plain_addr", 32'(csr_waddr), 32'h305);
        cmp("plain_data", csr_wdata, 32'h8000_0000);
        step();
        cmp("plain_out_valid", 32'(out_valid), 32'd1);
        cmp("plain_wen_done", 32'(csr_wen), 32'd0);
        step();
        cmp("plain_out_valid_drop", 32'(out_valid), 32'd0);
        cmp("plain_in_ready", 32'(in_ready), 32'd1);

        // Trap with MIE set
        mstatus_rdata = 32'h0000_0008;
        set_instr(1'b0, 12'h000, 32'h0, 1'b1, 8'h0B, 32'h8000_0102, 1'b0);
        step();
        in_valid = 1'b0;
        cmp("trap_mepc_addr", 32'(csr_waddr), 32'h341);
        cmp("trap_mepc_data", csr_wdata, 32'h8000_0100);
        step();
        cmp("trap_mcause_addr", 32'(csr_waddr), 32'h342);
        cmp("trap_mcause_data", csr_wdata, 32'h0000_000B);
        step();
        cmp("trap_mstatus_addr", 32'(csr_waddr), 32'h300);
        cmp("trap_mstatus_data", csr_wdata, 32'h0000_1880);
        cmp("trap_no_valid_yet", 32'(out_valid), 32'd0);
        step();
        cmp("trap_out_valid", 32'(out_valid), 32'd1);
        step();

        // Trap overrides a plain write
        set_instr(1'b1, 12'h305, 32'hDEAD_BEEF, 1'b1, 8'h87, 32'h0000_1000, 1'b0);
        step();
        in_valid = 1'b0;
        cmp("ovr_first_addr", 32'(csr_waddr), 32'h341);
        step();
        cmp("ovr_mcause", csr_wdata, 32'h8000_0007);
        step();
        cmp("ovr_last_addr", 32'(csr_waddr), 32'h300);
        step();
        step();

        // mret
        mstatus_rdata = 32'h0000_1880;
        set_instr(1'b0, 12'h000, 32'h0, 1'b0, 8'h00, 32'h0, 1'b1);
        step();
        in_valid = 1'b0;
        cmp("mret_addr", 32'(csr_waddr), 32'h300);
        cmp("mret_data", csr_wdata, 32'h0000_1888);
        step();
        cmp("mret_out_valid", 32'(out_valid), 32'd1);
        step();

        // Backpressure with a waiting instruction
        out_ready = 1'b0;
        set_instr(1'b1, 12'h305, 32'h1111_1111, 1'b0, 8'h00, 32'h0, 1'b0);
        step();
        set_instr(1'b1, 12'h340, 32'h2222_2222, 1'b0, 8'h00, 32'h0, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            cmp("bp_out_valid", 32'(out_valid), 32'd1);
            cmp("bp_in_ready", 32'(in_ready), 32'd0);
            cmp("bp_wen", 32'(csr_wen), 32'd0);
            if (i < 4) step();
        end
        out_ready = 1'b1;
        step();
        cmp("bp_idle_in_ready", 32'(in_ready), 32'd1);
        cmp("bp_idle_wen", 32'(csr_wen), 32'd0);
        step();
        in_valid = 1'b0;
        cmp("bp_next_addr", 32'(csr_waddr), 32'h340);
        cmp("bp_next_data", csr_wdata, 32'h2222_2222);
        step();
        step();

        // Reset in the middle of a trap
        set_instr(1'b0, 12'h000, 32'h0, 1'b1, 8'h03, 32'h0000_2000, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        cmp("rmid_in_mcause", 32'(csr_waddr), 32'h342);
        reset = 1'b1;
        step();
        reset = 1'b0;
        cmp("rmid_wen", 32'(csr_wen), 32'd0);
        cmp("rmid_out_valid", 32'(out_valid), 32'd0);
        cmp("rmid_in_ready", 32'(in_ready), 32'd1);
        step();
        cmp("rmid_no_mstatus", 32'(csr_wen), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid      = ($urandom_range(1, 0) == 1);
            csr_we_i      = ($urandom_range(1, 0) == 1);
            csr_addr_i    = 12'($urandom);
            csr_wdata_i   = $urandom;
            irq_i         = ($urandom_range(3, 0) == 0);
            irq_no_i      = 8'($urandom);
            epc_i         = $urandom;
            mret_i        = ($urandom_range(3, 0) == 0);
            mstatus_rdata = $urandom;
            out_ready     = ($urandom_range(9, 0) < 6);
            reset         = ($urandom_range(99, 0) == 0);
            step();
        end
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
